// File: rtl/inst_queue_pkg.sv
// Shared types and widths for the dual-lane instruction queue.
package inst_queue_pkg;

    localparam int unsigned ENTRY_W = 64;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned INST_W  = 32;

    // Field offsets inside one entry: {pc, inst}.
    localparam int unsigned INST_LSB = 0;
    localparam int unsigned PC_LSB   = INST_LSB + INST_W;

    // Two-lane bus widths on either side of the queue.
    localparam int unsigned PRE_TO_IBUS_W  = 2 * ENTRY_W;
    localparam int unsigned TO_NEXT_OBUS_W = 2 * ENTRY_W;

    // Retire count requested by the launch stage.
    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    // lane2 is the younger entry and sits in the upper half of the bus.
    typedef struct packed {
        entry_t lane2;
        entry_t lane1;
    } entry_pair_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and launch-side handshake bundle of the instruction queue.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic                      line1_pre_to_now_valid_i;
    logic                      line2_pre_to_now_valid_i;
    logic [PRE_TO_IBUS_W-1:0]  pre_to_ibus;
    logic                      now_allowin_o;
    logic                      excep_flush_i;
    logic                      branch_flush_i;
    logic                      line1_now_to_next_valid_o;
    logic                      line2_now_to_next_valid_o;
    logic [TO_NEXT_OBUS_W-1:0] to_next_obus;
    logic                      pop_double_i;
    logic                      pop_single_i;

    // Surrounding pipeline: fetch, flush sources and launch.
    modport master (
        output line1_pre_to_now_valid_i, line2_pre_to_now_valid_i, pre_to_ibus,
        output excep_flush_i, branch_flush_i, pop_double_i, pop_single_i,
        input  now_allowin_o, line1_now_to_next_valid_o, line2_now_to_next_valid_o,
        input  to_next_obus
    );

    // The queue itself.
    modport slave (
        input  line1_pre_to_now_valid_i, line2_pre_to_now_valid_i, pre_to_ibus,
        input  excep_flush_i, branch_flush_i, pop_double_i, pop_single_i,
        output now_allowin_o, line1_now_to_next_valid_o, line2_now_to_next_valid_o,
        output to_next_obus
    );

endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage: two write ports, two asynchronous read ports, no reset.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             we0_i,
    input  logic [PTR_W-1:0] waddr0_i,
    input  entry_t           wdata0_i,
    input  logic             we1_i,
    input  logic [PTR_W-1:0] waddr1_i,
    input  entry_t           wdata1_i,
    input  logic [PTR_W-1:0] raddr0_i,
    output entry_t           rdata0_o,
    input  logic [PTR_W-1:0] raddr1_i,
    output entry_t           rdata1_o
);

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    // Merge both write ports; their addresses are always distinct.
    always_comb begin
        mem_d = mem_q;
        if (we0_i) mem_d[waddr0_i] = wdata0_i;
        if (we1_i) mem_d[waddr1_i] = wdata1_i;
    end

    // Storage update.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Zero-latency read of head and head+1.
    always_comb begin
        rdata0_o = mem_q[raddr0_i];
        rdata1_o = mem_q[raddr1_i];
    end

endmodule

// File: rtl/inst_queue.sv
// Dual-lane circular instruction queue feeding the launch stage.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        flush, allowin, push_fire;
    logic        we0, we1;
    logic [1:0]  push_n, pop_n;
    logic        pop_over_c;
    pop_e        pop_req;
    entry_pair_t in_pair;
    entry_t      wd0, wd1, rd0, rd1, lane1_out, lane2_out;
    logic        v1, v2;

    // Admission: only a full pair's worth of space opens the input.
    always_comb begin
        flush     = bus.excep_flush_i | bus.branch_flush_i;
        allowin   = ~rst & (count_q <= CNT_W'(DEPTH - 2));
        push_fire = allowin & ~flush;
        bus.now_allowin_o = allowin;
    end

    // Write lanes; a lone lane2 entry is compacted into the tail slot.
    always_comb begin
        in_pair = entry_pair_t'(bus.pre_to_ibus);
        we0     = push_fire & (bus.line1_pre_to_now_valid_i | bus.line2_pre_to_now_valid_i);
        we1     = push_fire & bus.line1_pre_to_now_valid_i & bus.line2_pre_to_now_valid_i;
        wd0     = bus.line1_pre_to_now_valid_i ? in_pair.lane1 : in_pair.lane2;
        wd1     = in_pair.lane2;
        push_n  = {1'b0, we0} + {1'b0, we1};
    end

    // Retire count: double wins, clamped to occupancy, dropped on flush.
    always_comb begin
        pop_req = POP_NONE;
        if (bus.pop_double_i)      pop_req = POP_TWO;
        else if (bus.pop_single_i) pop_req = POP_ONE;
        pop_over_c = ~flush & (CNT_W'(pop_req) > count_q);
        if (flush)           pop_n = 2'(POP_NONE);
        else if (pop_over_c) pop_n = count_q[1:0];
        else                 pop_n = 2'(pop_req);
    end

    // Pointer and occupancy next state; flush empties the queue.
    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .we0_i    (we0),
        .waddr0_i (tail_q),
        .wdata0_i (wd0),
        .we1_i    (we1),
        .waddr1_i (tail_q + PTR_W'(1)),
        .wdata1_i (wd1),
        .raddr0_i (head_q),
        .rdata0_o (rd0),
        .raddr1_i (head_q + PTR_W'(1)),
        .rdata1_o (rd1)
    );

    // Present the two oldest entries, zeroed when not valid.
    always_comb begin
        v1        = (count_q >= CNT_W'(1)) & ~flush;
        v2        = (count_q >= CNT_W'(2)) & ~flush;
        lane1_out = v1 ? rd0 : entry_t'(0);
        lane2_out = v2 ? rd1 : entry_t'(0);
        bus.line1_now_to_next_valid_o = v1;
        bus.line2_now_to_next_valid_o = v2;
        bus.to_next_obus              = {lane2_out, lane1_out};
    end

    // Launch must never retire more entries than are held.
    a_pop_le_count: assert property (@(posedge clk) disable iff (rst) !pop_over_c);

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue against a queue-based model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_queue_if q_if();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (q_if.slave)
    );

    logic [63:0] mq[$];
    int n_checks = 0;
    int n_errors = 0;

    // Model expectations for the presented lanes given the current flush inputs.
    function automatic logic [127:0] exp_obus();
        logic [63:0] a = '0;
        logic [63:0] b = '0;
        logic f = q_if.excep_flush_i | q_if.branch_flush_i;
        if (!f && mq.size() >= 1) a = mq[0];
        if (!f && mq.size() >= 2) b = mq[1];
        return {b, a};
    endfunction

    task automatic set_idle();
        q_if.line1_pre_to_now_valid_i = 1'b0;
        q_if.line2_pre_to_now_valid_i = 1'b0;
        q_if.pre_to_ibus              = '0;
        q_if.excep_flush_i            = 1'b0;
        q_if.branch_flush_i           = 1'b0;
        q_if.pop_double_i             = 1'b0;
        q_if.pop_single_i             = 1'b0;
    endtask

    task automatic set_push(input logic v1, input logic v2, input logic [31:0] pc1, input logic [31:0] pc2);
        q_if.line1_pre_to_now_valid_i = v1;
        q_if.line2_pre_to_now_valid_i = v2;
        q_if.pre_to_ibus              = {pc2, 32'($urandom()), pc1, 32'($urandom())};
    endtask

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        logic f;
        logic ok;
        int   req;
        @(posedge clk);
        f  = q_if.excep_flush_i | q_if.branch_flush_i;
        ok = !rst && (mq.size() <= DEPTH - 2);
        if (rst || f) begin
            mq.delete();
        end else begin
            req = q_if.pop_double_i ? 2 : (q_if.pop_single_i ? 1 : 0);
            if (req > mq.size()) req = mq.size();
            for (int i = 0; i < req; i++) void'(mq.pop_front());
            if (ok && q_if.line1_pre_to_now_valid_i) mq.push_back(q_if.pre_to_ibus[63:0]);
            if (ok && q_if.line2_pre_to_now_valid_i) mq.push_back(q_if.pre_to_ibus[127:64]);
        end
        #1;
    endtask

    task automatic clear_q();
        set_idle();
        q_if.excep_flush_i = 1'b1;
        tick();
        set_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        set_push(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0044);
        tick();
        n_checks++;
        if (q_if.now_allowin_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_allowin_in_rst got=%b exp=0", q_if.now_allowin_o);
        end
        tick();
        n_checks++;
        if ({q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o} !== 2'b00) begin
            n_errors++; $display("FAIL reset_valid_in_rst got=%b%b exp=00",
                q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o);
        end
        rst = 1'b0;
        set_idle();
        #1;
        n_checks++;
        if (q_if.now_allowin_o !== 1'b1) begin
            n_errors++; $display("FAIL reset_allowin got=%b exp=1", q_if.now_allowin_o);
        end
        n_checks++;
        if ({q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o} !== 2'b00) begin
            n_errors++; $display("FAIL reset_valids got=%b%b exp=00",
                q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o);
        end
        n_checks++;
        if (q_if.to_next_obus !== 128'h0) begin
            n_errors++; $display("FAIL reset_obus got=%h exp=0", q_if.to_next_obus);
        end
    endtask

    task automatic test_push_pair();
        set_push(1'b1, 1'b1, 32'h1c00_0000, 32'h1c00_0004);
        #1;
        n_checks++;
        if (q_if.line1_now_to_next_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL pair_no_bypass got=%b exp=0", q_if.line1_now_to_next_valid_o);
        end
        tick();
        set_idle();
        #1;
        n_checks++;
        if ({q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o} !== 2'b11) begin
            n_errors++; $display("FAIL pair_valids got=%b%b exp=11",
                q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o);
        end
        n_checks++;
        if (q_if.to_next_obus[63:32] !== 32'h1c00_0000 || q_if.to_next_obus[127:96] !== 32'h1c00_0004) begin
            n_errors++; $display("FAIL pair_pcs got=%h/%h exp=1c000000/1c000004",
                q_if.to_next_obus[63:32], q_if.to_next_obus[127:96]);
        end
        n_checks++;
        if (int'(dut.count_q) !== 2) begin
            n_errors++; $display("FAIL pair_count got=%0d exp=2", dut.count_q);
        end
    endtask

    task automatic test_full();
        clear_q();
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 1'b1, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
            tick();
        end
        set_push(1'b1, 1'b1, 32'h9000, 32'h9004);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (q_if.now_allowin_o !== 1'b0 || int'(dut.count_q) !== 8) begin
                n_errors++; $display("FAIL full_hold cyc=%0d allowin=%b count=%0d exp allowin=0 count=8",
                    i, q_if.now_allowin_o, dut.count_q);
            end
            tick();
        end
        set_idle();
        q_if.pop_single_i = 1'b1;
        tick();
        n_checks++;
        if (q_if.now_allowin_o !== 1'b0 || int'(dut.count_q) !== 7) begin
            n_errors++; $display("FAIL full_minus1 allowin=%b count=%0d exp allowin=0 count=7",
                q_if.now_allowin_o, dut.count_q);
        end
        tick();
        set_idle();
        #1;
        n_checks++;
        if (q_if.now_allowin_o !== 1'b1 || int'(dut.count_q) !== 6) begin
            n_errors++; $display("FAIL full_minus2 allowin=%b count=%0d exp allowin=1 count=6",
                q_if.now_allowin_o, dut.count_q);
        end
        n_checks++;
        if (q_if.to_next_obus[63:32] !== 32'h1008 || q_if.to_next_obus[127:96] !== 32'h100c) begin
            n_errors++; $display("FAIL full_head got=%h/%h exp=1008/100c",
                q_if.to_next_obus[63:32], q_if.to_next_obus[127:96]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base = 32'h0000_2000;
        clear_q();
        set_push(1'b1, 1'b1, base, base + 32'd4);
        tick();
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (q_if.to_next_obus[63:32] !== base + 32'(8 * k) ||
                q_if.to_next_obus[127:96] !== base + 32'(8 * k + 4) ||
                int'(dut.count_q) !== 2) begin
                n_errors++; $display("FAIL stream k=%0d got=%h/%h count=%0d exp=%h/%h count=2", k,
                    q_if.to_next_obus[63:32], q_if.to_next_obus[127:96], dut.count_q,
                    base + 32'(8 * k), base + 32'(8 * k + 4));
            end
            set_push(1'b1, 1'b1, base + 32'(8 * (k + 1)), base + 32'(8 * (k + 1) + 4));
            q_if.pop_double_i = 1'b1;
            tick();
        end
        set_idle();
    endtask

    task automatic test_lane2_compact();
        clear_q();
        set_push(1'b1, 1'b1, 32'h10, 32'h14);
        tick();
        set_push(1'b1, 1'b0, 32'h18, 32'h0);
        tick();
        set_push(1'b0, 1'b1, 32'hdead, 32'h100);
        q_if.pop_single_i = 1'b1;
        tick();
        set_idle();
        #1;
        n_checks++;
        if (int'(dut.count_q) !== 3 || q_if.to_next_obus[63:32] !== 32'h14 || q_if.to_next_obus[127:96] !== 32'h18) begin
            n_errors++; $display("FAIL compact_state count=%0d pcs=%h/%h exp count=3 pcs=14/18",
                dut.count_q, q_if.to_next_obus[63:32], q_if.to_next_obus[127:96]);
        end
        q_if.pop_double_i = 1'b1;
        tick();
        set_idle();
        #1;
        n_checks++;
        if (int'(dut.count_q) !== 1 || q_if.to_next_obus[63:32] !== 32'h100 || q_if.line2_now_to_next_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL compact_third count=%0d pc=%h v2=%b exp count=1 pc=100 v2=0",
                dut.count_q, q_if.to_next_obus[63:32], q_if.line2_now_to_next_valid_o);
        end
    endtask

    task automatic test_flush();
        for (int src = 0; src < 3; src++) begin
            clear_q();
            set_push(1'b1, 1'b1, 32'h300, 32'h304);
            tick();
            set_push(1'b1, 1'b1, 32'h308, 32'h30c);
            tick();
            set_push(1'b1, 1'b0, 32'h310, 32'h0);
            tick();
            set_push(1'b1, 1'b1, 32'h400, 32'h404);
            q_if.pop_double_i = 1'b1;
            if (src == 1) q_if.branch_flush_i = 1'b1;
            else          q_if.excep_flush_i  = 1'b1;
            if (src == 2) rst = 1'b1;
            #1;
            n_checks++;
            if ({q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o} !== 2'b00 ||
                q_if.to_next_obus !== 128'h0) begin
                n_errors++; $display("FAIL flush_cycle src=%0d valids=%b%b obus=%h exp valids=00 obus=0", src,
                    q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o, q_if.to_next_obus);
            end
            tick();
            rst = 1'b0;
            set_idle();
            #1;
            n_checks++;
            if (int'(dut.count_q) !== 0 || q_if.now_allowin_o !== 1'b1 ||
                {q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o} !== 2'b00) begin
                n_errors++; $display("FAIL flush_after src=%0d count=%0d allowin=%b valids=%b%b exp 0/1/00", src,
                    dut.count_q, q_if.now_allowin_o, q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o);
            end
        end
    endtask

    task automatic test_random();
        logic f;
        int   sz;
        int   mode;
        for (int c = 0; c < 400; c++) begin
            sz = mq.size();
            set_idle();
            set_push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom()), 32'($urandom()));
            f = ($urandom_range(0, 15) == 0);
            q_if.excep_flush_i  = f & 1'($urandom_range(0, 1));
            q_if.branch_flush_i = f & ~q_if.excep_flush_i;
            mode = $urandom_range(0, 3);
            if (sz >= 2) begin
                q_if.pop_single_i = (mode == 1 || mode == 3);
                q_if.pop_double_i = (mode == 2 || mode == 3);
            end else if (sz == 1) begin
                q_if.pop_single_i = (mode != 0);
            end
            #1;
            n_checks++;
            if (q_if.now_allowin_o !== (sz <= DEPTH - 2)) begin
                n_errors++; $display("FAIL rand_allowin c=%0d got=%b model_size=%0d", c, q_if.now_allowin_o, sz);
            end
            n_checks++;
            if (q_if.line1_now_to_next_valid_o !== (!f && sz >= 1) ||
                q_if.line2_now_to_next_valid_o !== (!f && sz >= 2)) begin
                n_errors++; $display("FAIL rand_valids c=%0d got=%b%b model_size=%0d flush=%b", c,
                    q_if.line1_now_to_next_valid_o, q_if.line2_now_to_next_valid_o, sz, f);
            end
            n_checks++;
            if (q_if.to_next_obus !== exp_obus()) begin
                n_errors++; $display("FAIL rand_obus c=%0d got=%h exp=%h", c, q_if.to_next_obus, exp_obus());
            end
            tick();
            n_checks++;
            if (int'(dut.count_q) !== mq.size()) begin
                n_errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, dut.count_q, mq.size());
            end
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_push_pair();
        test_full();
        test_back_to_back();
        test_lane2_compact();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-lane circular instruction buffer, directly upstream of the launch stage.
- Accepts up to two fetched/pre-decoded instructions per cycle from the fetch side.
- Always presents the two oldest entries to the launch stage.
- Retires zero, one or two entries per cycle, as reported by the launch stage's double/single issue decision; a flush empties it.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- ENTRY_W, 64, bits per entry ({pc[31:0], inst[31:0]}).
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- line1_pre_to_now_valid_i  in  1  fetch lane1 entry valid.
- line2_pre_to_now_valid_i  in  1  fetch lane2 entry valid (younger than lane1).
- pre_to_ibus  in  2*ENTRY_W  {lane2_entry, lane1_entry}.
- now_allowin_o  out  1  queue can accept a full pair this cycle.
- excep_flush_i  in  1  exception flush.
- branch_flush_i  in  1  branch-mispredict flush.
- line1_now_to_next_valid_o  out  1  head entry valid toward launch.
- line2_now_to_next_valid_o  out  1  head+1 entry valid toward launch.
- to_next_obus  out  2*ENTRY_W  {head+1 entry, head entry}.
- pop_double_i  in  1  launch issued both presented entries this cycle.
- pop_single_i  in  1  launch issued only the head entry this cycle.

Behaviour:
- State: head_ptr[PTR_W-1:0], tail_ptr[PTR_W-1:0], count[PTR_W:0], storage DEPTH x ENTRY_W. Storage is not reset.
- Reset (rst=1 at edge): head_ptr=0, tail_ptr=0, count=0.
- While rst=1, now_allowin_o=0. Both line valids are 0 during and after reset until the first push.
- now_allowin_o = ~rst & (count <= DEPTH-2). This is combinational from registered count only.
- push_fire = now_allowin_o & ~flush, where flush = excep_flush_i | branch_flush_i.
- Push count:
  - both lanes valid: 2 entries; lane1 is written at tail, lane2 at tail+1.
  - lane1 only: 1 entry at tail.
  - lane2 only: lane2 is compacted and written at tail alone.
- Pushes presented while now_allowin_o=0 are ignored; the upstream must hold them.
- Outputs are combinational from registered state (zero-latency read):
  - line1_now_to_next_valid_o = (count>=1) & ~flush.
  - line2_now_to_next_valid_o = (count>=2) & ~flush.
  - The lane data at head and head+1 is masked to all-zero when the corresponding valid is 0.
- Pop count:
  - pop_double_i=1: 2. It takes precedence if both pop inputs are high.
  - else pop_single_i=1: 1.
  - else: 0.
- Pop is clamped to the current count. A pop exceeding count is a protocol error: flag it with a simulation assertion; the RTL clamps.
- Pops are ignored in a flush cycle.
- Same-cycle push and pop are legal:
  - count' = count + pushes - pops.
  - tail_ptr' = tail + pushes, head_ptr' = head + pops, both mod DEPTH (natural wrap).
- Full boundary: at count=DEPTH-1, allowin is 0 even though one slot is free. Pairs are never split.
- Empty boundary: at count=0 both valids are 0 and pops are ignored. A push into an empty queue is visible on the outputs the next cycle (no bypass).
- Flush (either source) at edge: head_ptr=tail_ptr=count=0. Same-cycle push and pop are discarded. Outputs are invalid in the flush cycle and in the following cycle unless new pushes arrive.
- Simultaneous flush and rst: rst wins; the result is identical.
- Wrap-around: entries that straddle index DEPTH-1 to index 0 must be read and written correctly in both lanes.

Decomposition:
- Shared package/header holds:
  - ENTRY_W and the pc/inst field offsets.
  - The IdToNextBusWidth-style bus width macros for 2*ENTRY_W.
  - A pop-count encoding constant (POP_NONE=0, POP_ONE=1, POP_TWO=2).
- One natural sub-module: inst_queue_ram.
  - DEPTH x ENTRY_W, two write ports at (tail, tail+1), two async read ports at (head, head+1).
  - Write-enable per port; no reset.
  - Pointer and count logic stay in inst_queue.

Test Plan:
- Reset then idle → after rst deassert, now_allowin_o=1, both valids 0, to_next_obus=0.
- Push pair {pc=0x1c000004, pc=0x1c000000} into empty queue, no pop → next cycle line1 data pc=0x1c000000, line2 data pc=0x1c000004, both valids 1, count=2.
- Fill with 4 pairs, no pops → count=8, now_allowin_o=0. A fifth pair held on input for 3 cycles is not written. Then pop_single_i → count=7, allowin stays 0. Then another pop_single_i → count=6, allowin=1.
- Steady stream: push 2/cycle and pop_double_i every cycle for 20 cycles (pointers wrap 5 times) → head pc sequence strictly +8 per cycle, no duplicates or holes, count constant at 2.
- Queue holds 3 entries, same cycle: lane2-only push (pc=0x100) + pop_single_i → count=3, and the third-oldest entry is pc=0x100.
- Queue holds 5 entries, excep_flush_i asserted together with a valid pair push and pop_double_i → next cycle count=0, both valids 0, allowin=1. Repeat with branch_flush_i → identical result.
